// File: rtl/shift_seq_arbiter.sv
// shift_seq_arbiter: round-robin sharing of one external WIDTH-bit shift register
//
// Each accepted request is a (direction, pattern) pair. The block clears the
// register, serially shifts the pattern in over WIDTH cycles, then pulses done.
// Sequence per op: IDLE -> CLEAR (1) -> SHIFT (WIDTH) -> DONE (1) -> IDLE.
//
// Optional feature macro: SEQ_READBACK_EN
//   defined   : rsp_data captures sr_data_out on the DONE edge and holds it
//   undefined : rsp_data is tied to 0 and sr_data_out is unused
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   reqN_valid/ready/dir/pattern    requester N command handshake (N = 0,1)
//   sr_reset, sr_direction,         drive the external shift register
//   sr_shift_in
//   sr_data_out                     external shift register parallel output
//   done, done_id                   one-cycle completion pulse and its requester
//   rsp_data                        readback of the register at completion
module shift_seq_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_dir,
    input  logic [WIDTH-1:0] req0_pattern,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_dir,
    input  logic [WIDTH-1:0] req1_pattern,
    output logic             sr_reset,
    output logic             sr_direction,
    output logic             sr_shift_in,
    input  logic [WIDTH-1:0] sr_data_out,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] rsp_data
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] seq_q, seq_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             idle;
    logic             grant;
    logic             accept;
    logic             last_shift;
    logic             sel_dir;
    logic [WIDTH-1:0] sel_pattern;

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        for (int i = 0; i < WIDTH; i++) rev[i] = v[WIDTH-1-i];
    endfunction

    // Round-robin: ptr_q names the favoured requester when both are valid.
    assign idle        = (state_q == IDLE) && !reset;
    assign grant       = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    assign accept      = idle && (req0_valid || req1_valid);
    assign last_shift  = cnt_q == CW'(WIDTH - 1);
    assign sel_dir     = grant ? req1_dir : req0_dir;
    assign sel_pattern = grant ? req1_pattern : req0_pattern;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            dir_q   <= 1'b0;
            seq_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dir_q   <= dir_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? CLEAR : IDLE;
            CLEAR:   state_d = SHIFT;
            SHIFT:   state_d = last_shift ? DONE : SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // seq_q holds the bits in transmit order, so the next bit is always bit 0;
    // a left shift sends the MSB first, hence the reversal on load.
    always_comb begin
        ptr_d = accept ? !grant : ptr_q;
        id_d  = accept ? grant : id_q;
        dir_d = accept ? sel_dir : dir_q;
        seq_d = accept ? (sel_dir ? sel_pattern : rev(sel_pattern))
                       : (state_q == SHIFT) ? seq_q >> 1 : seq_q;
        cnt_d = (state_q == SHIFT) ? cnt_q + CW'(1) : '0;
    end

    always_comb begin
        req0_ready   = accept && !grant;
        req1_ready   = accept && grant;
        sr_reset     = reset || (state_q == CLEAR);
        sr_direction = !reset && (state_q != IDLE) && dir_q;
        sr_shift_in  = !reset && (state_q == SHIFT) && seq_q[0];
        done         = !reset && (state_q == DONE);
        done_id      = done && id_q;
    end

`ifdef SEQ_READBACK_EN
    logic [WIDTH-1:0] rsp_q, rsp_d;

    always_comb rsp_d = (state_q == DONE) ? sr_data_out : rsp_q;

    always_ff @(posedge clk) begin
        if (reset) rsp_q <= '0;
        else       rsp_q <= rsp_d;
    end

    assign rsp_data = rsp_q;
`else
    logic unused_sr;
    assign unused_sr = ^sr_data_out;
    assign rsp_data  = '0;
`endif

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// tb_shift_seq_arbiter: directed self-checking bench with a behavioural shift register
module tb_shift_seq_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_dir;
    logic [3:0] req0_pattern;
    logic       req1_valid, req1_ready, req1_dir;
    logic [3:0] req1_pattern;
    logic       sr_reset, sr_direction, sr_shift_in;
    logic [3:0] sr_q;
    logic       done, done_id;
    logic [3:0] rsp_data;
    int         n_pass = 0;
    int         n_chk = 0;
    int         cyc = 0;
    int         acc_cyc;
    int         prev_acc;

    shift_seq_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dir(req0_dir), .req0_pattern(req0_pattern),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dir(req1_dir), .req1_pattern(req1_pattern),
        .sr_reset(sr_reset), .sr_direction(sr_direction), .sr_shift_in(sr_shift_in),
        .sr_data_out(sr_q), .done(done), .done_id(done_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sr_reset)          sr_q <= 4'b0;
        else if (sr_direction) sr_q <= {sr_shift_in, sr_q[3:1]};
        else                   sr_q <= {sr_q[2:0], sr_shift_in};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [3:0] readback(input logic [3:0] pat);
`ifdef SEQ_READBACK_EN
        return pat;
`else
        return 4'b0;
`endif
    endfunction

    // Called just after a negedge; returns at the accepting posedge.
    task automatic wait_grant(input logic exp_id);
        for (int i = 0; i < 20 && !(req0_ready || req1_ready); i++) begin
            @(negedge clk);
            #1;
        end
        check("grant_seen", req0_ready || req1_ready, 1);
        check("grant_id", req1_ready, exp_id);
        check("grant_onehot", req0_ready && req1_ready, 0);
        acc_cyc = cyc;
        @(posedge clk);
    endtask

    // Called at the accepting posedge; returns #1 after the DONE edge.
    task automatic op_trace(input logic id, input logic dir, input logic [3:0] pat);
        @(negedge clk);
        check("clr_sr_reset", sr_reset, 1);
        check("clr_dir", sr_direction, dir);
        check("clr_ready", {req0_ready, req1_ready}, 0);
        check("clr_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sh_bit", sr_shift_in, dir ? pat[k] : pat[3-k]);
            check("sh_dir", sr_direction, dir);
            check("sh_sr_reset", sr_reset, 0);
            check("sh_busy", {done, req0_ready, req1_ready}, 0);
        end
        @(negedge clk);
        check("done", done, 1);
        check("done_id", done_id, id);
        check("done_data", sr_q, pat);
        check("done_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk);
        #1;
        check("rsp_data", rsp_data, readback(pat));
        check("done_pulse", done, 0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_dir = 1'b0; req0_pattern = 4'b1000;
        req1_valid = 1'b0; req1_dir = 1'b0; req1_pattern = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_done", done, 0);
        check("rst_sr_reset", sr_reset, 1);
        check("rst_shift_in", sr_shift_in, 0);
        check("rst_dir", sr_direction, 0);
        check("rst_rsp", rsp_data, 0);
        reset = 1'b0;
        #1;
        check("idle_ready0", req0_ready, 1);
        check("idle_sr_reset", sr_reset, 0);

        // single left-shift op from requester 0
        wait_grant(0);
        #1;
        req0_valid = 1'b0; req0_pattern = 4'b0111; req0_dir = 1'b1;
        op_trace(0, 0, 4'b1000);

        // single right-shift op from requester 1
        req1_valid = 1'b1; req1_dir = 1'b1; req1_pattern = 4'b0001;
        @(negedge clk); #1;
        wait_grant(1);
        #1;
        req1_valid = 1'b0;
        op_trace(1, 1, 4'b0001);

        // both continuously valid: strict alternation, accepts 7 cycles apart
        req0_valid = 1'b1; req0_dir = 1'b0; req0_pattern = 4'b1010;
        req1_valid = 1'b1; req1_dir = 1'b1; req1_pattern = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            wait_grant(i[0]);
            if (i > 0) check("acc_spacing", acc_cyc - prev_acc, 7);
            prev_acc = acc_cyc;
            op_trace(i[0], i[0], i[0] ? 4'b0110 : 4'b1010);
        end
        req1_valid = 1'b0;

        // reset during the second SHIFT cycle drops the op
        req0_dir = 1'b0; req0_pattern = 4'b0101;
        @(negedge clk); #1;
        wait_grant(0);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_dir = 1'b1; req1_pattern = 4'b1001;
        repeat (2) @(negedge clk);
        #1;
        check("rst5_bit0", sr_shift_in, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst5_sr_reset", sr_reset, 1);
        check("rst5_done", done, 0);
        check("rst5_ready", req1_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst5_cleared", sr_q, 0);
        check("rst5_no_done", done, 0);
        check("rst5_shift_in", sr_shift_in, 0);
        check("rst5_dir", sr_direction, 0);
        check("rst5_rsp", rsp_data, 0);
        wait_grant(1);
        #1;
        req1_valid = 1'b0;
        op_trace(1, 1, 4'b1001);

        // requester 0 waits through a requester 1 op and uses its latest pattern
        req1_valid = 1'b1; req1_dir = 1'b0; req1_pattern = 4'b0011;
        @(negedge clk); #1;
        wait_grant(1);
        #1;
        req1_valid = 1'b0; req1_pattern = 4'b1111;
        req0_valid = 1'b1; req0_dir = 1'b1; req0_pattern = 4'b1111;
        fork
            op_trace(1, 0, 4'b0011);
            begin
                repeat (3) @(negedge clk);
                req0_pattern = 4'b0110;
            end
        join
        @(negedge clk); #1;
        wait_grant(0);
        #1;
        req0_valid = 1'b0;
        op_trace(0, 1, 4'b0110);

        @(negedge clk); #1;
        check("end_idle", {req0_ready, req1_ready, done}, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
